tt_sweep_ctrl: RTL and testbench
================================

TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE, default 2, meaning settle cycles per input vector, legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, sweep request, sampled only in IDLE.
REQ-005 The block SHALL have port expected, input, 16 bits, expected minterm mask; bit i is the expected output for vector i.
REQ-006 The block SHALL have port drive, output, 4 bits, vector to the combinational DUT as {A,B,C,D}, A = MSB.
REQ-007 The block SHALL have port y_in, input, 1 bit, DUT output.
REQ-008 The block SHALL have port busy, output, 1 bit, high in SETTLE and SAMPLE states.
REQ-009 The block SHALL have port done, output, 1 bit, one-cycle pulse at end of sweep.
REQ-010 The block SHALL have port table, output, 16 bits, captured truth table; bit i = y_in sampled while drive = i.
REQ-011 The block SHALL have port mismatch_count, output, 5 bits, number of bits where table differs from expected (0..16).
REQ-012 The block SHALL have port first_fail, output, 4 bits, lowest vector index that mismatched; 0 when none.
REQ-013 The block SHALL have port pass, output, 1 bit, high when mismatch_count = 0 after a completed sweep.

Function
REQ-014 The FSM SHALL have states IDLE, SETTLE, SAMPLE, DONE.
REQ-015 IDLE with start=1 SHALL latch expected, clear table, mismatch_count, first_fail and pass, set index=0, drive=0, and go to SETTLE.
REQ-016 SETTLE SHALL hold drive constant for exactly SETTLE cycles, then go to SAMPLE.
REQ-017 SAMPLE SHALL last one cycle: table[index] <= y_in; on mismatch with latched expected[index], mismatch_count increments, and first_fail <= index if it is the first mismatch.
REQ-018 In SAMPLE, index < 15 SHALL increment index and drive and return to SETTLE; index = 15 SHALL go to DONE.
REQ-019 DONE SHALL assert done for one cycle, set pass = (final mismatch_count = 0), and return to IDLE.
REQ-020 Latency SHALL be 16*(SETTLE+1)+1 cycles from the start-accept edge to the done-high cycle; 49 cycles for SETTLE=2.
REQ-021 start while busy or in DONE SHALL be ignored; the sweep is neither restarted nor queued.
REQ-022 Index SHALL saturate at 15 and never wrap; the mismatch_count width SHALL accommodate 16.
REQ-023 Changes to expected after start SHALL NOT affect the sweep in progress.
REQ-024 table, mismatch_count, first_fail and pass SHALL hold their values in IDLE until the next accepted start.
REQ-025 drive SHALL hold its last value in IDLE and DONE.

Reset
REQ-026 rst=1 at any clock edge, including mid-sweep, SHALL force IDLE, drive=0, table=0, mismatch_count=0, first_fail=0, pass=0, done=0, busy=0.
REQ-027 rst SHALL take priority over start in the same cycle.
REQ-028 No output SHALL change asynchronously to clk.

Structure
REQ-029 A shared package SHALL hold the FSM state enumeration, N_VEC=16, and the index width of 4.
REQ-030 The settle counter SHALL be one sub-module, tt_settle_timer, with load, count and expire, parameterised by SETTLE.
REQ-031 The DUT SHALL be external; it is connected only through drive and y_in.

Verification
REQ-032 DUT = Σm(4,5,6,7,11,12,13), expected=16'h38F0, start pulse -> done at cycle 49, table=16'h38F0, mismatch_count=0, pass=1.
REQ-033 Same DUT, expected=16'h38F1 -> table=16'h38F0, mismatch_count=1, first_fail=0, pass=0.
REQ-034 DUT output tied to 1, expected=16'h0000 -> mismatch_count=16, first_fail=0, table=16'hFFFF.
REQ-035 rst asserted at cycle 20 of a sweep -> next cycle all outputs at reset values, state IDLE; a new start then completes normally.
REQ-036 start held high for the whole sweep -> exactly one done pulse per sweep; the next sweep begins only on the IDLE cycle after DONE.
REQ-037 SETTLE=1 and SETTLE=15 builds -> done at cycles 33 and 257, with drive stable for SETTLE+1 cycles per vector.

Source files
------------

// File: rtl/tt_sweep_ctrl_pkg.sv
// Shared definitions for the truth-table sweep controller: FSM states,
// vector count and the index/counter widths derived from it.
package tt_sweep_ctrl_pkg;

  // Number of input vectors swept (four DUT inputs).
  localparam int N_VEC = 16;

  // Width of the vector index / drive bus.
  localparam int IDX_W = 4;

  // Mismatch counter must be able to hold N_VEC itself, not just N_VEC-1.
  localparam int CNT_W = 5;

  // Width of the settle-cycle counter (SETTLE is at most 15).
  localparam int TMR_W = 4;

  // Last vector index; the sweep ends after sampling it.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VEC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // True for the states in which a sweep is actively driving vectors.
  function automatic logic is_busy_state(input state_t st);
    return (st == ST_SETTLE) || (st == ST_SAMPLE);
  endfunction

endpackage

// File: rtl/tt_sweep_ctrl_settle.sv
// Settle timer: counts the cycles a vector is held before it is sampled.
// load arms it for SETTLE cycles; expire is high in the last of them.
module tt_settle_timer
  import tt_sweep_ctrl_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expire
);

  // Loading SETTLE-1 makes the count reach zero on the SETTLE-th cycle.
  localparam logic [TMR_W-1:0] RELOAD = TMR_W'(SETTLE - 1);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  // Next count: reload has priority, otherwise decrement down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (count && (cnt_q != '0)) begin
      cnt_d = cnt_q - TMR_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: drives all 16 input vectors into an external
// combinational DUT, samples y_in for each after a settle period, and compares
// the captured table against a latched expected minterm mask.
// The captured table port is named truth_table because "table" is a reserved
// word in SystemVerilog.
module tt_sweep_ctrl
  import tt_sweep_ctrl_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      expected,
  output logic [3:0]       drive,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic [15:0]      truth_table,
  output logic [4:0]       mismatch_count,
  output logic [3:0]       first_fail,
  output logic             pass
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_VEC-1:0]   exp_q, exp_d;
  logic [N_VEC-1:0]   tbl_q, tbl_d;
  logic [CNT_W-1:0]   mm_q, mm_d;
  logic [IDX_W-1:0]   ff_q, ff_d;
  logic               pass_q, pass_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               tmr_load;
  logic               tmr_count;
  logic               tmr_expire;
  logic               miss;

  tt_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .count  (tmr_count),
    .expire (tmr_expire)
  );

  // Current sample disagrees with the latched expectation for this vector.
  assign miss = (y_in != exp_q[idx_q]);

  // Next-state and datapath updates; every register holds unless its state acts.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    exp_d     = exp_q;
    tbl_d     = tbl_q;
    mm_d      = mm_q;
    ff_d      = ff_q;
    pass_d    = pass_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_count = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          exp_d    = expected;
          tbl_d    = '0;
          mm_d     = '0;
          ff_d     = '0;
          pass_d   = 1'b0;
          idx_d    = '0;
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (tmr_expire) begin
          state_d = ST_SAMPLE;
        end else begin
          tmr_count = 1'b1;
        end
      end

      ST_SAMPLE: begin
        tbl_d[idx_q] = y_in;
        if (miss) begin
          mm_d = mm_q + CNT_W'(1);
          if (mm_q == '0) begin
            ff_d = idx_q;
          end
        end
        if (idx_q == LAST_IDX) begin
          // pass and done become visible together in the DONE cycle.
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (mm_d == '0);
        end else begin
          idx_d    = idx_q + IDX_W'(1);
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = is_busy_state(state_d);
  end

  // State and output registers; all outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      exp_q   <= '0;
      tbl_q   <= '0;
      mm_q    <= '0;
      ff_q    <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      tbl_q   <= tbl_d;
      mm_q    <= mm_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign drive          = idx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign truth_table    = tbl_q;
  assign mismatch_count = mm_q;
  assign first_fail     = ff_q;
  assign pass           = pass_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: three instances (SETTLE = 2, 1, 15) each driving a
// mask-defined combinational DUT, checked every cycle against a cycle-count
// model of the sweep plus literal expectations for the known vectors.
module tb_tt_sweep_ctrl;

  localparam int NI = 3;

  function automatic int settle_of(input int i);
    case (i)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  typedef struct packed {
    logic [15:0] tbl;
    logic [4:0]  cnt;
    logic [3:0]  ff;
  } res_t;

  logic        clk;
  logic        rst;
  logic        start       [NI];
  logic [15:0] expected    [NI];
  logic [15:0] dut_mask    [NI];
  logic [3:0]  drive       [NI];
  logic        y_in        [NI];
  logic        busy        [NI];
  logic        done        [NI];
  logic [15:0] truth_table [NI];
  logic [4:0]  mcount      [NI];
  logic [3:0]  first_fail  [NI];
  logic        pass        [NI];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    assign y_in[gi] = dut_mask[gi][drive[gi]];
    tt_sweep_ctrl #(
      .SETTLE (settle_of(gi))
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start[gi]),
      .expected       (expected[gi]),
      .drive          (drive[gi]),
      .y_in           (y_in[gi]),
      .busy           (busy[gi]),
      .done           (done[gi]),
      .truth_table    (truth_table[gi]),
      .mismatch_count (mcount[gi]),
      .first_fail     (first_fail[gi]),
      .pass           (pass[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int i, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] t=%0t actual=%h required=%h", name, i, $time, act, exp);
    end
  endtask

  // Results visible in sweep cycle k: vector v is sampled in cycle (v+1)(s+1)
  // and its bit shows up from the following cycle on.
  function automatic res_t partial(input int s, input int k, input logic [15:0] dm,
                                   input logic [15:0] ex);
    res_t r;
    bit   found;
    r     = '0;
    found = 0;
    for (int v = 0; v < 16; v++) begin
      if ((v + 1) * (s + 1) < k) begin
        r.tbl[v] = dm[v];
        if (dm[v] != ex[v]) begin
          r.cnt = r.cnt + 5'd1;
          if (!found) r.ff = 4'(v);
          found = 1;
        end
      end
    end
    return r;
  endfunction

  // Model state: k counts cycles since the accepting edge (1 = first SETTLE cycle).
  bit          m_active [NI];
  int          m_k      [NI];
  logic [15:0] m_exp    [NI];
  res_t        m_held   [NI];
  logic        m_hpass  [NI];
  logic [3:0]  m_hdrive [NI];

  // Reference model advances on the same edge as the DUT.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int s, last;
      s    = settle_of(i);
      last = 16 * (s + 1) + 1;
      if (rst) begin
        m_active[i] <= 0;
        m_held[i]   <= '0;
        m_hpass[i]  <= 1'b0;
        m_hdrive[i] <= 4'd0;
      end else if (!m_active[i]) begin
        if (start[i]) begin
          m_active[i] <= 1;
          m_k[i]      <= 1;
          m_exp[i]    <= expected[i];
        end
      end else if (m_k[i] == last) begin
        m_active[i] <= 0;
        m_held[i]   <= partial(s, m_k[i], dut_mask[i], m_exp[i]);
        m_hpass[i]  <= (partial(s, m_k[i], dut_mask[i], m_exp[i]).cnt == 5'd0);
        m_hdrive[i] <= 4'd15;
      end else begin
        m_k[i] <= m_k[i] + 1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        int   s, len;
        res_t r;
        logic e_busy, e_done, e_pass;
        logic [3:0] e_drive;
        s = settle_of(i);
        len = 16 * (s + 1);
        if (m_active[i]) begin
          e_busy  = (m_k[i] <= len);
          e_done  = (m_k[i] == len + 1);
          e_drive = e_busy ? 4'((m_k[i] - 1) / (s + 1)) : 4'd15;
          r       = partial(s, m_k[i], dut_mask[i], m_exp[i]);
          e_pass  = e_done && (r.cnt == 5'd0);
        end else begin
          e_busy  = 1'b0;
          e_done  = 1'b0;
          e_drive = m_hdrive[i];
          r       = m_held[i];
          e_pass  = m_hpass[i];
        end
        check("busy",  i, 16'(busy[i]),       16'(e_busy));
        check("done",  i, 16'(done[i]),       16'(e_done));
        check("drive", i, 16'(drive[i]),      16'(e_drive));
        check("table", i, truth_table[i],     r.tbl);
        check("count", i, 16'(mcount[i]),     16'(r.cnt));
        check("ffail", i, 16'(first_fail[i]), 16'(r.ff));
        check("pass",  i, 16'(pass[i]),       16'(e_pass));
      end
    end
  end

  // Wait (bounded) for done on instance i, counting cycles since the accept edge.
  task automatic wait_done(input int i, input bit junk, output int lat);
    bit got;
    got = 0;
    lat = 0;
    while (!got && lat < 400) begin
      @(negedge clk);
      lat++;
      if (done[i]) begin
        got = 1;
      end else if (junk) begin
        #1;
        expected[i] = 16'($urandom);
        start[i]    = 1'($urandom_range(0, 1));
      end
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout[%0d] actual=no done after %0d cycles required=done", i, lat);
    end
    #1;
    start[i] = 1'b0;
  endtask

  task automatic run_sweep(input int i, input logic [15:0] dm, input logic [15:0] ex,
                           input bit junk, output int lat);
    @(negedge clk);
    #1;
    dut_mask[i] = dm;
    expected[i] = ex;
    start[i]    = 1'b1;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
    wait_done(i, junk, lat);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start[i]    = 1'b0;
      expected[i] = 16'h0;
      dut_mask[i] = 16'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    @(negedge clk);
    check("rst_drive", 0, 16'(drive[0]), 16'h0);
    check("rst_busy",  0, 16'(busy[0]),  16'h0);
    #1;
    rst = 1'b0;

    // Known DUT sum(4,5,6,7,11,12,13) = 16'h38F0.
    run_sweep(0, 16'h38F0, 16'h38F0, 0, lat);
    $display("sweep inst0 exp=38F0 lat=%0d table=%h cnt=%0d pass=%0d", lat, truth_table[0], mcount[0], pass[0]);
    check("lat49",  0, 16'(lat), 16'd49);
    check("tbl_a",  0, truth_table[0], 16'h38F0);
    check("cnt_a",  0, 16'(mcount[0]), 16'd0);
    check("pass_a", 0, 16'(pass[0]), 16'd1);

    run_sweep(0, 16'h38F0, 16'h38F1, 0, lat);
    $display("sweep inst0 exp=38F1 lat=%0d table=%h cnt=%0d ff=%0d pass=%0d", lat, truth_table[0], mcount[0], first_fail[0], pass[0]);
    check("tbl_b",  0, truth_table[0], 16'h38F0);
    check("cnt_b",  0, 16'(mcount[0]), 16'd1);
    check("ff_b",   0, 16'(first_fail[0]), 16'd0);
    check("pass_b", 0, 16'(pass[0]), 16'd0);

    run_sweep(0, 16'hFFFF, 16'h0000, 0, lat);
    $display("sweep inst0 y=1 exp=0000 lat=%0d table=%h cnt=%0d ff=%0d", lat, truth_table[0], mcount[0], first_fail[0]);
    check("tbl_c", 0, truth_table[0], 16'hFFFF);
    check("cnt_c", 0, 16'(mcount[0]), 16'd16);
    check("ff_c",  0, 16'(first_fail[0]), 16'd0);
    repeat (5) @(negedge clk);
    check("hold_tbl", 0, truth_table[0], 16'hFFFF);
    check("hold_drv", 0, 16'(drive[0]), 16'd15);

    // Reset in cycle 20 of a sweep.
    @(negedge clk);
    #1;
    dut_mask[0] = 16'h38F0;
    expected[0] = 16'h0F0F;
    start[0]    = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    $display("reset mid-sweep busy=%0d drive=%0d table=%h", busy[0], drive[0], truth_table[0]);
    check("mrst_busy",  0, 16'(busy[0]), 16'd0);
    check("mrst_drive", 0, 16'(drive[0]), 16'd0);
    check("mrst_tbl",   0, truth_table[0], 16'h0);
    check("mrst_cnt",   0, 16'(mcount[0]), 16'd0);
    #1;
    rst = 1'b0;
    run_sweep(0, 16'h38F0, 16'h38F0, 0, lat);
    $display("sweep after reset lat=%0d pass=%0d", lat, pass[0]);
    check("lat_rst", 0, 16'(lat), 16'd49);
    check("pass_rst", 0, 16'(pass[0]), 16'd1);

    // start held high: one done, restart only after the IDLE cycle.
    @(negedge clk);
    #1;
    expected[0] = 16'h38F0;
    start[0]    = 1'b1;
    @(posedge clk);
    lat = 0;
    while (!done[0] && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("hold_lat", 0, 16'(lat), 16'd49);
    @(negedge clk);
    check("hold_idle", 0, 16'(busy[0]), 16'd0);
    @(negedge clk);
    check("hold_rest", 0, 16'(busy[0]), 16'd1);
    $display("held start: lat=%0d restart observed busy=%0d", lat, busy[0]);
    #1;
    start[0] = 1'b0;
    wait_done(0, 0, lat);

    // Other settle lengths.
    run_sweep(1, 16'($urandom), 16'($urandom), 0, lat);
    $display("sweep inst1 (SETTLE=1) lat=%0d cnt=%0d", lat, mcount[1]);
    check("lat33", 1, 16'(lat), 16'd33);
    run_sweep(2, 16'($urandom), 16'($urandom), 0, lat);
    $display("sweep inst2 (SETTLE=15) lat=%0d cnt=%0d", lat, mcount[2]);
    check("lat257", 2, 16'(lat), 16'd257);

    // Random sweeps with expected/start churn during the sweep.
    for (int n = 0; n < 10; n++) begin
      int i;
      i = (n % 2);
      run_sweep(i, 16'($urandom), 16'($urandom), 1, lat);
      $display("random sweep %0d inst%0d lat=%0d table=%h cnt=%0d ff=%0d pass=%0d",
               n, i, lat, truth_table[i], mcount[i], first_fail[i], pass[i]);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
